// File: rtl/fetch_queue.sv
// fetch_queue -- instruction prefetch queue between instruction memory and decode.
// Issues sequential word fetches ahead of decode, buffers up to DEPTH
// {pc, instruction} pairs and restarts from a new PC on a taken branch/jump.
// At most one memory request is outstanding; a response still owed after a
// redirect is swallowed in DISCARD so it can never be mistaken for new data.
module fetch_queue #(
   parameter int          DEPTH      = 4,        // power of two, at least 2
   parameter logic [31:0] START_ADDR = 32'h1000
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     mem_req,
   output logic [31:0]              mem_addr,
   input  logic [31:0]              mem_r_data,
   input  logic [1:0]               mem_r_status,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   input  logic                     stall,
   output logic [31:0]              inst,
   output logic [31:0]              inst_pc,
   output logic                     inst_valid,
   output logic                     fetch_err,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int            AW   = $clog2(DEPTH);
   localparam int            CW   = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD, ERR} state_t;

   // Memory response encoding seen on mem_r_status.
   typedef enum logic [1:0] {
      RSP_IDLE = 2'b00,
      RSP_BUSY = 2'b01,
      RSP_DATA = 2'b10,
      RSP_BERR = 2'b11
   } rsp_t;

   state_t        state;
   rsp_t          rsp;
   logic [31:0]   fetch_pc;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   data_mem [DEPTH];

   logic          do_pop;
   logic          do_push;
   logic          rsp_done;
   logic [CW-1:0] occ_after_pop;
   logic [CW-1:0] occ_after_push;

   assign rsp = rsp_t'(mem_r_status);

   // Per-cycle queue movement and the occupancy it leads to at the edge.
   always_comb begin
      do_pop         = (count != '0) && !stall;
      do_push        = !redirect && (state == REQ) && (rsp == RSP_DATA);
      // Both 10 and 11 close the outstanding request.
      rsp_done       = mem_r_status[1];
      occ_after_pop  = count - CW'(do_pop);
      occ_after_push = occ_after_pop + CW'(do_push);
   end

   // Fetch control FSM: state, fetch PC, sticky error and registered request.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         fetch_pc  <= START_ADDR;
         fetch_err <= 1'b0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc;
         if (redirect_pc[1:0] != 2'b00) begin
            state     <= ERR;
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
         end else begin
            fetch_err <= 1'b0;
            unique case (state)
               REQ, DISCARD: begin
                  // A response still owed must be swallowed before refetching.
                  if (rsp_done) begin
                     state   <= REQ;
                     mem_req <= 1'b1;
                  end else begin
                     state   <= DISCARD;
                     mem_req <= 1'b0;
                  end
               end
               default: begin
                  state   <= REQ;
                  mem_req <= 1'b1;
               end
            endcase
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (occ_after_pop < FULL) begin
                  state   <= REQ;
                  mem_req <= 1'b1;
               end
            end
            REQ: begin
               if (rsp == RSP_DATA) begin
                  fetch_pc <= fetch_pc + 32'd4;
                  if (occ_after_push >= FULL) begin
                     state   <= IDLE;
                     mem_req <= 1'b0;
                  end
               end else if (rsp == RSP_BERR) begin
                  state     <= ERR;
                  mem_req   <= 1'b0;
                  fetch_err <= 1'b1;
               end
            end
            DISCARD: begin
               // Stale response consumed without a push; a stale bus error is not reported.
               if (rsp_done) begin
                  state   <= REQ;
                  mem_req <= 1'b1;
               end
            end
            ERR: begin
               // Parked until a redirect; the queue keeps draining meanwhile.
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   // Queue pointers and occupancy; a redirect empties the queue outright.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= occ_after_push;
      end
   end

   // Entry storage, written at the end of the response cycle.
   // NOTE: the storage array has no reset; entries are only visible through
   // count, which is reset, so stale contents can never reach decode.
   always_ff @(posedge clk) begin
      if (do_push) begin
         pc_mem[wr_ptr]   <= fetch_pc;
         data_mem[wr_ptr] <= mem_r_data;
      end
   end

   assign mem_addr   = fetch_pc;
   assign inst_valid = (count != '0);
   assign inst       = inst_valid ? data_mem[rd_ptr] : 32'h0;
   assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : 32'h0;
   assign occupancy  = count;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the instruction memory and the decode stage of the MIPS32 pipeline. Issues sequential word fetches ahead of decode, buffers up to `DEPTH` {pc, instruction} pairs, and absorbs variable memory latency and decode stalls. On a taken branch or jump from the memory stage, the block flushes all buffered and in-flight fetches and refetches from the target.

## Interface
- `DEPTH`, 4: queue entries; power of two, minimum 2.
- `START_ADDR`, 32'h1000: fetch PC after reset.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  fetch request; held high until a response is returned.
- `mem_addr`  out  32  fetch address; stable while `mem_req` is high.
- `mem_r_data`  in  32  instruction word; valid only when `mem_r_status` is 2'b10.
- `mem_r_status`  in  2  memory response:
  - 00: idle.
  - 01: busy.
  - 10: data valid this cycle.
  - 11: bus error this cycle.
- `redirect`  in  1  flush and restart fetching at `redirect_pc`.
- `redirect_pc`  in  32  target PC for the redirect.
- `stall`  in  1  decode cannot accept an instruction this cycle.
- `inst`  out  32  instruction at the head of the queue; 32'h0 (NOP) when the queue is empty.
- `inst_pc`  out  32  PC of `inst`; 32'h0 when the queue is empty.
- `inst_valid`  out  1  queue is not empty.
- `fetch_err`  out  1  sticky fetch error.
- `occupancy`  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- State machine states: IDLE, REQ, DISCARD, ERR. Reset state is IDLE.
- Values after reset:
  - `fetch_pc` = `START_ADDR`.
  - Queue empty; `occupancy` = 0.
  - `mem_req` = 0, `inst_valid` = 0, `fetch_err` = 0, `inst` = 0, `inst_pc` = 0.
- `mem_req` is 1 only in REQ. `mem_addr` = `fetch_pc` at all times.
- Only one memory request is outstanding at any time.
- IDLE:
  - Go to REQ when the queue has free space, i.e. `occupancy` after this cycle's dequeue < `DEPTH`.
- REQ:
  - Status 10:
    - Push {`fetch_pc`, `mem_r_data`} into the queue.
    - `fetch_pc` += 4, with 32-bit wrap (32'hFFFFFFFC wraps to 0).
    - Stay in REQ if free space remains after the push and this cycle's dequeue; otherwise go to IDLE.
  - Status 11: go to ERR and set `fetch_err`.
  - Status 00 or 01: stay in REQ.
- Dequeue: when `inst_valid` && !`stall`, the head entry is popped at the edge. A pop on an empty queue is ignored.
- A push and a pop in the same cycle leave `occupancy` unchanged. This applies when the queue is full as well.
- `redirect` has the highest priority over push, pop, stall and error. On `redirect`:
  - The queue is emptied.
  - `fetch_pc` = `redirect_pc`.
  - If `redirect_pc[1:0]` != 0: go to ERR and set `fetch_err`.
  - Else, in REQ with status 00 or 01 this cycle: go to DISCARD, because the stale response is still owed.
  - Else, in REQ with status 10 or 11 this cycle: the response is dropped and the next state is REQ.
  - Else, in IDLE, DISCARD or ERR: go to REQ and clear `fetch_err`. A redirect in DISCARD keeps DISCARD if its response has not yet arrived.
- DISCARD:
  - `mem_req` = 0. The response is consumed without a push.
  - Status 10 or 11: go to REQ. A bus error on a discarded fetch does not set `fetch_err`.
- ERR:
  - No requests are issued. The queue drains normally through decode.
  - Only `redirect` or reset leaves ERR.

## Timing
- Memory response returned in cycle N:
  - Entry is written at the end of cycle N.
  - `inst_valid` is high in cycle N+1.
  - The next request's `mem_addr` is presented in cycle N+1.
- There is no combinational path from `mem_r_data` to `inst`.
- With a 1-cycle memory and no stall, the block sustains one instruction per cycle after a 2-cycle startup.
- Redirect asserted in cycle N:
  - `inst_valid` = 0 in cycle N+1.
  - `mem_req` = 1 for the target in cycle N+1, unless DISCARD is entered.
- Asynchronous reset asserted mid-request:
  - All outputs return to their reset values immediately.
  - Any later memory response is ignored, since the state is IDLE.

## Test plan
- Reset release, memory with 1-cycle latency returns `inst` = 32'h20080001 for address 32'h1000 -> `mem_addr` = 32'h1000 in the first cycle after release; `inst_valid` = 1 with `inst_pc` = 32'h1000 two cycles later; `mem_addr` advances to 32'h1004.
- `stall` held high, `DEPTH` = 4 -> `occupancy` reaches 4, then `mem_req` drops. Releasing `stall` drains entries at one per cycle with `inst_pc` sequence 32'h1000, 32'h1004, 32'h1008, 32'h100C; fetching resumes at 32'h1010.
- Memory busy (status 01) for 3 cycles, `redirect` to 32'h2000 in the 2nd busy cycle -> state goes to DISCARD with `mem_req` = 0; the stale response is not enqueued; the next request is at 32'h2000.
- Status 11 on fetch 32'h1008 -> `fetch_err` = 1, no further requests, the entries for 32'h1000 and 32'h1004 still drain. A later `redirect` to 32'h1000 clears `fetch_err` and restarts fetching.
- Full queue with push and pop in the same cycle -> `occupancy` stays 4; FIFO order is preserved. `redirect` to 32'h1002 -> `fetch_err` = 1, queue empty.
